// File: rtl/sm83_irq_pkg.sv
// Shared types and constants for the sm83 interrupt controller.
// IME state encoding, standard line indices and the RST vector helper.
package sm83_irq_pkg;

    typedef enum logic [1:0] {
        IME_OFF  = 2'd0,
        IME_PEND = 2'd1,
        IME_ON   = 2'd2
    } ime_state_t;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    function automatic logic [7:0] irq_vector(input logic [2:0] idx);
        return 8'h40 + {2'b00, idx, 3'b000};
    endfunction

endpackage

// File: rtl/sm83_irq_prio.sv
// Fixed-priority selector: one-hot of the lowest set request bit, plus an any-set flag.
// Purely combinational; bit 0 has the highest priority.
module sm83_irq_prio
    import sm83_irq_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic             any
);

    // Scan from the top down so the last hit (lowest index) wins.
    always_comb begin
        grant = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sm83_irq_ctl.sv
// Interrupt controller for the sm83 core: IF/IE registers, IME sequencing, priority and HALT wake.
// Define SM83_IRQ_SYNC_EN to put a 2-flop synchroniser in front of the edge detector.
//
//   state    | meaning
//   IME_OFF  | interrupts masked
//   IME_PEND | EI seen, enable at the next instruction boundary
//   IME_ON   | interrupts dispatched to the core
module sm83_irq_ctl
    import sm83_irq_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int NUM_IRQS  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_IRQS-1:0]  irq_src,
    input  logic                 reg_sel,
    input  logic                 reg_we,
    input  logic [WORD_SIZE-1:0] reg_din,
    output logic [WORD_SIZE-1:0] reg_dout,
    input  logic                 ime_ei,
    input  logic                 ime_reti,
    input  logic                 ime_di,
    input  logic                 insn_end,
    output logic [WORD_SIZE-1:0] irq,
    input  logic [WORD_SIZE-1:0] iack,
    output logic                 wake
);

    logic [NUM_IRQS-1:0]  src_s;
    logic [NUM_IRQS-1:0]  src_prev;
    logic [NUM_IRQS-1:0]  edge_det;
    logic [NUM_IRQS-1:0]  if_q;
    logic [NUM_IRQS-1:0]  if_d;
    logic [WORD_SIZE-1:0] ie_q;
    logic [WORD_SIZE-1:0] if_wide;
    logic [NUM_IRQS-1:0]  pending;
    logic [NUM_IRQS-1:0]  grant;
    logic                 any_pending;
    ime_state_t           ime_q;
    ime_state_t           ime_d;

`ifdef SM83_IRQ_SYNC_EN
    logic [NUM_IRQS-1:0] sync1;
    logic [NUM_IRQS-1:0] sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
        end
    end

    assign src_s = sync2;
`else
    assign src_s = irq_src;
`endif

    always_ff @(posedge clk) begin
        if (reset) src_prev <= '0;
        else       src_prev <= src_s;
    end

    assign edge_det = src_s & ~src_prev;

    // Later assignments win: new edge beats acknowledge beats software write.
    always_comb begin
        if_d = if_q;
        for (int i = 0; i < NUM_IRQS; i++) begin
            if (reg_we && !reg_sel) if_d[i] = reg_din[i];
            if (iack[i])            if_d[i] = 1'b0;
            if (edge_det[i])        if_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_q <= '0;
            ie_q <= '0;
        end else begin
            if_q <= if_d;
            if (reg_we && reg_sel) ie_q <= reg_din;
        end
    end

    always_comb begin
        ime_d = ime_q;
        if (ime_di) begin
            ime_d = IME_OFF;
        end else if (ime_reti) begin
            ime_d = IME_ON;
        end else begin
            case (ime_q)
                IME_OFF:  if (ime_ei)   ime_d = IME_PEND;
                IME_PEND: if (insn_end) ime_d = IME_ON;
                IME_ON:   ime_d = IME_ON;
                default:  ime_d = IME_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ime_q <= IME_OFF;
        else       ime_q <= ime_d;
    end

    assign pending = if_q & ie_q[NUM_IRQS-1:0];

    sm83_irq_prio #(.WIDTH(NUM_IRQS)) u_prio (
        .req   (pending),
        .grant (grant),
        .any   (any_pending)
    );

    always_comb begin
        irq = '0;
        if (ime_q == IME_ON) irq[NUM_IRQS-1:0] = grant;
    end

    assign wake = any_pending;

    // Unimplemented IF bits read back as ones.
    always_comb begin
        if_wide                = '1;
        if_wide[NUM_IRQS-1:0]  = if_q;
    end

    assign reg_dout = reg_sel ? ie_q : if_wide;

    iack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(iack));

endmodule
